// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception controller: ExcCodes, FSM encoding
// and the EPC computation used on exception/interrupt entry.
package cp0_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTER   = 2'd1,
      ST_HANDLER = 2'd2,
      ST_RETURN  = 2'd3
   } state_t;

   // A delay-slot instruction restarts at its branch, one word earlier.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
      if (in_ds) begin
         epc_of = pc - 32'd4;
      end else begin
         epc_of = pc;
      end
   endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer for the six raw device interrupt lines.
// SYNC_STAGES is expected to be 2 or 3.
module int_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] d,
   output logic [5:0] q
);

   logic [5:0] sync_q [SYNC_STAGES];
   logic [5:0] sync_d [SYNC_STAGES];

   // Shift chain: stage 0 samples the pins, later stages follow.
   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 6'd0;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt entry and eret return controller; drives the write side
// of Cause, EPC and Status.EXL plus the pipeline flush/redirect.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   input  logic        status_ie,
   input  logic        status_exl,
   input  logic [5:0]  status_im,
   input  logic        m_valid,
   input  logic        m_exc,
   input  logic [4:0]  m_exc_code,
   input  logic        m_in_ds,
   input  logic [31:0] m_pc,
   input  logic        m_eret,
   input  logic [31:0] epc_in,
   output logic        ip_we,
   output logic [5:0]  ip,
   output logic        ecode_we,
   output logic [4:0]  exc_code,
   output logic        bd_set,
   output logic        bd_clr,
   output logic        epc_we,
   output logic [31:0] epc_data,
   output logic        exl_set,
   output logic        exl_clr,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        nested_err
);

   state_t      state_q, state_d;
   logic        ip_we_q, ip_we_d;
   logic        ecode_we_q, ecode_we_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic        bd_set_q, bd_set_d;
   logic        bd_clr_q, bd_clr_d;
   logic        epc_we_q, epc_we_d;
   logic [31:0] epc_data_q, epc_data_d;
   logic        exl_set_q, exl_set_d;
   logic        exl_clr_q, exl_clr_d;
   logic        flush_q, flush_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        nested_err_q, nested_err_d;
   logic        int_take_s;
   logic        exc_take_s;
   logic [5:0]  ip_s;

   int_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_int_sync (
      .clk  (clk),
      .reset(reset),
      .d    (hw_int),
      .q    (ip_s)
   );

   // Take decisions and next-state/pulse computation; pulses are registered
   // so they appear exactly during the ENTER/RETURN cycle.
   always_comb begin
      state_d       = state_q;
      ip_we_d       = 1'b1;
      ecode_we_d    = 1'b0;
      exc_code_d    = 5'd0;
      bd_set_d      = 1'b0;
      bd_clr_d      = 1'b0;
      epc_we_d      = 1'b0;
      epc_data_d    = 32'd0;
      exl_set_d     = 1'b0;
      exl_clr_d     = 1'b0;
      flush_d       = 1'b0;
      redirect_d    = 1'b0;
      redirect_pc_d = 32'd0;
      nested_err_d  = nested_err_q;

      int_take_s = m_valid & status_ie & ~status_exl & (|(ip_s & status_im));
      exc_take_s = m_valid & m_exc & ~status_exl;

      case (state_q)
         ST_IDLE: begin
            if (int_take_s || exc_take_s) begin
               state_d       = ST_ENTER;
               ecode_we_d    = 1'b1;
               exc_code_d    = int_take_s ? EXC_INT : m_exc_code;
               epc_we_d      = 1'b1;
               epc_data_d    = epc_of(m_pc, m_in_ds);
               bd_set_d      = m_in_ds;
               bd_clr_d      = ~m_in_ds;
               exl_set_d     = 1'b1;
               flush_d       = 1'b1;
               redirect_d    = 1'b1;
               redirect_pc_d = HANDLER_ADDR;
            end else if (m_valid && m_eret) begin
               state_d       = ST_RETURN;
               exl_clr_d     = 1'b1;
               bd_clr_d      = 1'b1;
               flush_d       = 1'b1;
               redirect_d    = 1'b1;
               redirect_pc_d = epc_in;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ENTER: begin
            state_d = ST_HANDLER;
         end
         // Inside the handler interrupts are masked; a fault here is only recorded.
         ST_HANDLER: begin
            if (m_valid && m_exc) begin
               nested_err_d = 1'b1;
            end else if (m_valid && m_eret) begin
               state_d       = ST_RETURN;
               exl_clr_d     = 1'b1;
               bd_clr_d      = 1'b1;
               flush_d       = 1'b1;
               redirect_d    = 1'b1;
               redirect_pc_d = epc_in;
            end else begin
               state_d = ST_HANDLER;
            end
         end
         ST_RETURN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ip_we_q       <= 1'b0;
         ecode_we_q    <= 1'b0;
         exc_code_q    <= 5'd0;
         bd_set_q      <= 1'b0;
         bd_clr_q      <= 1'b0;
         epc_we_q      <= 1'b0;
         epc_data_q    <= 32'd0;
         exl_set_q     <= 1'b0;
         exl_clr_q     <= 1'b0;
         flush_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
         nested_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         ip_we_q       <= ip_we_d;
         ecode_we_q    <= ecode_we_d;
         exc_code_q    <= exc_code_d;
         bd_set_q      <= bd_set_d;
         bd_clr_q      <= bd_clr_d;
         epc_we_q      <= epc_we_d;
         epc_data_q    <= epc_data_d;
         exl_set_q     <= exl_set_d;
         exl_clr_q     <= exl_clr_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         nested_err_q  <= nested_err_d;
      end
   end

   assign ip_we       = ip_we_q;
   assign ip          = ip_s;
   assign ecode_we    = ecode_we_q;
   assign exc_code    = exc_code_q;
   assign bd_set      = bd_set_q;
   assign bd_clr      = bd_clr_q;
   assign epc_we      = epc_we_q;
   assign epc_data    = epc_data_q;
   assign exl_set     = exl_set_q;
   assign exl_clr     = exl_clr_q;
   assign flush       = flush_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign nested_err  = nested_err_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: a cycle model pushes the expected output
// vector for each driven cycle, and it is popped and compared after the edge.
module tb_cp0_exc_ctrl;

   typedef struct packed {
      logic        ip_we;
      logic [5:0]  ip;
      logic        ecode_we;
      logic [4:0]  exc_code;
      logic        bd_set;
      logic        bd_clr;
      logic        epc_we;
      logic [31:0] epc_data;
      logic        exl_set;
      logic        exl_clr;
      logic        flush;
      logic        redirect;
      logic [31:0] redirect_pc;
      logic        nested_err;
   } out_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hw_int;
   logic        status_ie, status_exl;
   logic [5:0]  status_im;
   logic        m_valid, m_exc, m_in_ds, m_eret;
   logic [4:0]  m_exc_code;
   logic [31:0] m_pc, epc_in;
   logic        ip_we, ecode_we, bd_set, bd_clr, epc_we, exl_set, exl_clr;
   logic        flush, redirect, nested_err;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc_data, redirect_pc;

   int   checks = 0;
   int   failures = 0;
   out_t exp_q[$];

   // Bench-side model state (2 sync stages).
   int         mstate;
   logic [5:0] msync0, msync1;
   logic       mnested;

   cp0_exc_ctrl dut (
      .clk(clk), .reset(reset), .hw_int(hw_int),
      .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
      .m_valid(m_valid), .m_exc(m_exc), .m_exc_code(m_exc_code),
      .m_in_ds(m_in_ds), .m_pc(m_pc), .m_eret(m_eret), .epc_in(epc_in),
      .ip_we(ip_we), .ip(ip), .ecode_we(ecode_we), .exc_code(exc_code),
      .bd_set(bd_set), .bd_clr(bd_clr), .epc_we(epc_we), .epc_data(epc_data),
      .exl_set(exl_set), .exl_clr(exl_clr), .flush(flush), .redirect(redirect),
      .redirect_pc(redirect_pc), .nested_err(nested_err)
   );

   always #5 clk = ~clk;

   function automatic out_t dut_vec();
      out_t v;
      v = '{ip_we, ip, ecode_we, exc_code, bd_set, bd_clr, epc_we, epc_data,
            exl_set, exl_clr, flush, redirect, redirect_pc, nested_err};
      return v;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mstate  = 0;
      msync0  = 6'd0;
      msync1  = 6'd0;
      mnested = 1'b0;
   endtask

   // Predict the outputs after the next edge, push, clock, pop and compare.
   task automatic cycle(input string tag);
      out_t e;
      out_t got;
      logic itake, etake;
      int   nstate;
      e = '0;
      e.ip_we = 1'b1;
      e.ip = msync0;
      nstate = mstate;
      itake = m_valid & status_ie & ~status_exl & (|(msync1 & status_im));
      etake = m_valid & m_exc & ~status_exl;
      if (mstate == 0) begin
         if (itake || etake) begin
            e.ecode_we = 1'b1;
            e.exc_code = itake ? 5'd0 : m_exc_code;
            e.epc_we = 1'b1;
            e.epc_data = m_in_ds ? (m_pc - 32'd4) : m_pc;
            e.bd_set = m_in_ds;
            e.bd_clr = ~m_in_ds;
            e.exl_set = 1'b1;
            e.flush = 1'b1;
            e.redirect = 1'b1;
            e.redirect_pc = 32'h0000_4180;
            nstate = 1;
         end else if (m_valid && m_eret) begin
            e.exl_clr = 1'b1; e.bd_clr = 1'b1; e.flush = 1'b1; e.redirect = 1'b1;
            e.redirect_pc = epc_in;
            nstate = 3;
         end
      end else if (mstate == 1) begin
         nstate = 2;
      end else if (mstate == 2) begin
         if (m_valid && m_exc) begin
            mnested = 1'b1;
         end else if (m_valid && m_eret) begin
            e.exl_clr = 1'b1; e.bd_clr = 1'b1; e.flush = 1'b1; e.redirect = 1'b1;
            e.redirect_pc = epc_in;
            nstate = 3;
         end
      end else begin
         nstate = 0;
      end
      e.nested_err = mnested;
      exp_q.push_back(e);
      msync1 = msync0;
      msync0 = hw_int;
      mstate = nstate;
      @(posedge clk);
      #1;
      got = dut_vec();
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 128'd1, 128'd0);
      end else begin
         check(tag, got, exp_q.pop_front());
      end
   endtask

   task automatic m_idle();
      m_valid = 1'b0; m_exc = 1'b0; m_eret = 1'b0; m_in_ds = 1'b0;
      m_exc_code = 5'd0;
   endtask

   initial begin
      reset = 1'b1;
      hw_int = 6'd0; status_ie = 1'b0; status_exl = 1'b0; status_im = 6'd0;
      m_pc = 32'd0; epc_in = 32'd0;
      m_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", dut_vec(), 128'd0);
      reset = 1'b0;

      // Idle after reset.
      repeat (3) cycle("idle");

      // Interrupt on line 0: two sync cycles then the decision.
      status_ie = 1'b1; status_im = 6'b000001;
      hw_int = 6'b000001; m_valid = 1'b1; m_pc = 32'h3010;
      repeat (3) cycle("int_entry");
      check("t2_ecode_we", ecode_we, 1'b1);
      check("t2_code", exc_code, 5'd0);
      check("t2_epc", epc_data, 32'h3010);
      check("t2_bd_clr", bd_clr, 1'b1);
      check("t2_rpc", redirect_pc, 32'h4180);
      m_idle(); status_exl = 1'b1; hw_int = 6'd0;
      cycle("t2_enter_next");
      m_valid = 1'b1; m_eret = 1'b1; epc_in = 32'h3010;
      cycle("t2_eret");
      check("t2_ret_rpc", redirect_pc, 32'h3010);
      m_idle(); status_exl = 1'b0;
      repeat (3) cycle("t2_drain");

      // Synchronous overflow in a delay slot.
      m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd12; m_in_ds = 1'b1; m_pc = 32'h3024;
      cycle("t3_exc");
      check("t3_code", exc_code, 5'd12);
      check("t3_epc", epc_data, 32'h3020);
      check("t3_bd_set", bd_set, 1'b1);
      check("t3_exl_flush", {exl_set, flush}, 2'b11);
      m_idle(); status_exl = 1'b1;
      repeat (2) cycle("t3_handler");
      m_valid = 1'b1; m_eret = 1'b1; epc_in = 32'h3020;
      cycle("t4_eret");
      check("t4_exl_clr", {exl_clr, bd_clr, redirect}, 3'b111);
      check("t4_rpc", redirect_pc, 32'h3020);
      m_idle(); status_exl = 1'b0;
      cycle("t4_idle");
      check("t4_no_pulse", {flush, redirect, exl_clr}, 3'b000);

      // Pending interrupt and an address-error exception together.
      hw_int = 6'b000001;
      repeat (2) cycle("t5_sync");
      m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4; m_pc = 32'h3100;
      cycle("t5_take");
      check("t5_code", exc_code, 5'd0);
      check("t5_epc", epc_data, 32'h3100);
      m_idle(); status_exl = 1'b1;
      cycle("t5_enter_next");
      m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd10;
      cycle("t5_nested");
      check("t5_nested_err", nested_err, 1'b1);
      m_idle();
      cycle("t5_hold");
      m_valid = 1'b1; m_eret = 1'b1; epc_in = 32'h3100;
      cycle("t5_eret");
      m_idle(); status_exl = 1'b0;
      cycle("t5_idle");

      // Re-take the still-pending interrupt, then reset mid-ENTER.
      m_valid = 1'b1; m_pc = 32'h3200;
      cycle("t6_take");
      check("t6_enter", ecode_we, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_abort", dut_vec(), 128'd0);
      exp_q.delete();
      model_reset();
      m_idle();
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_valid = 1'b1; m_pc = 32'h3300;
      repeat (3) cycle("t6_reenter");
      check("t6_reenter_we", ecode_we, 1'b1);
      check("t6_reenter_epc", epc_data, 32'h3300);
      m_idle(); status_exl = 1'b1;
      repeat (2) cycle("t6_tail");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt entry-and-return controller for the P7 CPU. It is the writer side of the CP0 Cause register.
- Samples device interrupt lines and M-stage exception requests, and arbitrates them against Status (IE, EXL, IM).
- Drives the Cause write-side controls (IP, ExcCode, BD), EPC and Status.EXL updates, and the pipeline flush/PC redirect.
- Also handles eret return.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, PC loaded on exception/interrupt entry
- SYNC_STAGES, 2, flop stages on each hw_int line (legal values 2..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hw_int  in  6  raw device interrupt lines, asynchronous
- status_ie  in  1  Status.IE
- status_exl  in  1  Status.EXL
- status_im  in  6  Status.IM[15:10]
- m_valid  in  1  M-stage holds a real instruction (not a bubble)
- m_exc  in  1  M-stage instruction raised a synchronous exception
- m_exc_code  in  5  ExcCode of that exception
- m_in_ds  in  1  M-stage instruction is in a branch delay slot
- m_pc  in  32  PC of the M-stage instruction
- m_eret  in  1  M-stage instruction is eret
- epc_in  in  32  current EPC value
- ip_we  out  1  Cause.IP write enable
- ip  out  6  synchronized pending interrupt lines
- ecode_we  out  1  Cause.ExcCode write enable
- exc_code  out  5  ExcCode to write
- bd_set  out  1  set Cause.BD
- bd_clr  out  1  clear Cause.BD
- epc_we  out  1  EPC write enable
- epc_data  out  32  EPC value to write
- exl_set  out  1  set Status.EXL
- exl_clr  out  1  clear Status.EXL
- flush  out  1  flush F/D/E/M pipeline registers
- redirect  out  1  load PC from redirect_pc
- redirect_pc  out  32  target PC
- nested_err  out  1  sticky flag: exception raised inside the handler

Behaviour:
- **Reset:** all outputs 0, synchronizers cleared, state = IDLE, nested_err = 0.
- **Sync:** each hw_int bit passes through SYNC_STAGES flops; ip = last stage.
  - ip_we = 1 every cycle except during reset.
  - Latency from pin to ip is SYNC_STAGES cycles.
- **Combinational take conditions** (evaluated in IDLE only):
  - int_take = m_valid & status_ie & ~status_exl & |(ip & status_im)
  - exc_take = m_valid & m_exc & ~status_exl
  - Priority: int_take over exc_take. An eret in the same cycle is ignored when either take is true.
- **On take:** capture into registers:
  - code: 0 if interrupt, else m_exc_code
  - bd = m_in_ds
  - epc = m_in_ds ? m_pc-4 : m_pc (32-bit wrap on subtract)
  - Then go to ENTER.
- **eret in IDLE** (m_valid & m_eret, no take): capture epc_in, go to RETURN.
- **States:**
  - IDLE: no pulses.
  - ENTER (exactly 1 cycle):
    - ecode_we=1, exc_code=code
    - epc_we=1, epc_data=epc
    - bd_set=bd, bd_clr=~bd
    - exl_set=1, flush=1, redirect=1, redirect_pc=HANDLER_ADDR
    - Next state: HANDLER.
  - HANDLER:
    - No interrupts taken.
    - m_valid & m_exc sets nested_err (sticky until reset); nothing else happens.
    - m_valid & m_eret captures epc_in and goes to RETURN.
  - RETURN (exactly 1 cycle): exl_clr=1, bd_clr=1, flush=1, redirect=1, redirect_pc = captured epc_in. Next state: IDLE.
- **Output timing:** all pulse outputs are registered and high for exactly one cycle. No pulse may occur in IDLE or HANDLER.
- **Decision-cycle hold:** the cycle after a take decision, m_* inputs are don't-care, because the M stage is being flushed in that cycle.
- **Reset mid-ENTER/RETURN:** the pulse is aborted and the state returns to IDLE immediately (asynchronous).
- **Simultaneous m_exc and pending interrupt:** the interrupt wins; EPC = the faulting instruction's PC, so it re-executes and re-raises the exception after eret.

Decomposition:
- Shared package (cp0_pkg): ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12), the state encoding (IDLE, ENTER, HANDLER, RETURN), and HANDLER_ADDR default.
- One sub-module: int_sync (SYNC_STAGES-deep, 6-bit synchronizer, asynchronous reset).

Test Plan:
1. Reset then idle, hw_int=0 → all pulses 0; ip_we=1, ip=0; nested_err=0.
2. status_ie=1, exl=0, im=6'b000001; hw_int[0] rises; m_valid=1, m_pc=32'h3010, m_in_ds=0 → after 2-cycle sync plus decision: one ENTER cycle with exc_code=0, epc_data=32'h3010, bd_clr=1, redirect_pc=32'h4180.
3. m_exc=1, code=5'd12, m_in_ds=1, m_pc=32'h3024 → ENTER with exc_code=12, epc_data=32'h3020, bd_set=1, exl_set=1, flush=1.
4. In HANDLER, m_eret=1, epc_in=32'h3020 → one RETURN cycle with exl_clr=1, bd_clr=1, redirect_pc=32'h3020; then IDLE.
5. Interrupt pending plus m_exc=1 (code 4) in the same cycle → exc_code=0; then m_exc in HANDLER → nested_err=1 with no ENTER pulse.
6. Assert reset during the ENTER cycle → pulses drop at once; state IDLE; after release, the next valid interrupt re-enters normally.
